wb_trace_uart_tx: RTL and testbench

Streams processor writeback activity off-chip over a UART, independently of the on-chip debug cores. Sits beside `RISC_V_RV32F_PROCESSOR_POWER_OPT` in the top level. It watches the integer writeback bus, the FP writeback bus and the FP flags, and queues a snapshot whenever any of them changes. It then serializes each snapshot as a fixed 10-byte frame on an 8N1 line.

---
 rtl/trace_pkg.sv | 44 ++++
 rtl/trace_fifo.sv | 50 +++++
 rtl/wb_trace_uart_tx.sv | 206 ++++++++++++++++++++
 tb/tb_wb_trace_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the writeback trace UART: snapshot layout,
// frame constants and transmitter states.
package trace_pkg;

  localparam logic [7:0]  TRACE_SYNC_BYTE   = 8'hA5;
  localparam int unsigned TRACE_FRAME_BYTES = 10;
  localparam int unsigned TRACE_ENTRY_W     = 71;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic        chg_int;
    logic        chg_fp;
    logic [4:0]  flags;
    logic [31:0] int_data;
    logic [31:0] fp_data;
  } trace_entry_t;

  // Byte idx of the on-wire frame for a captured snapshot.
  function automatic logic [7:0] frame_byte(input trace_entry_t e, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0: b = TRACE_SYNC_BYTE;
      4'd1: b = {1'b0, e.flags, e.chg_fp, e.chg_int};
      4'd2: b = e.int_data[7:0];
      4'd3: b = e.int_data[15:8];
      4'd4: b = e.int_data[23:16];
      4'd5: b = e.int_data[31:24];
      4'd6: b = e.fp_data[7:0];
      4'd7: b = e.fp_data[15:8];
      4'd8: b = e.fp_data[23:16];
      4'd9: b = e.fp_data[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous snapshot FIFO; pointers wrap modulo DEPTH (power of two).
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata_c,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata_c = r_mem[r_rptr];
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/wb_trace_uart_tx.sv
// Captures writeback/FP-flag changes into a FIFO and streams each snapshot
// as a 10-byte 8N1 frame on uart_txd.
module wb_trace_uart_tx
  import trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] int_wb_data,
  input  logic [31:0] fp_wb_data_out,
  input  logic [4:0]  fp_flags_out,
  input  logic        overflow_clr,
  output logic        uart_txd,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_BYTE = 4'(TRACE_FRAME_BYTES - 1);

  logic [31:0]      r_prev_int;
  logic [31:0]      r_prev_fp;
  logic [4:0]       r_prev_flags;
  logic             w_chg_int;
  logic             w_chg_fp;
  logic             w_push_req;
  logic             w_push_ok;
  logic             w_drop;
  trace_entry_t     w_entry;
  trace_entry_t     w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_nxt;
  logic [2:0]       w_bit_inc;
  logic [3:0]       r_byte_idx;
  logic [3:0]       w_byte_nxt;
  logic             r_txd;
  logic             w_txd_nxt;
  logic             w_pop;
  logic             w_baud_done;
  logic [7:0]       w_cur_byte;
  trace_entry_t     r_frame;
  logic             r_busy;
  logic             r_overflow;

  // Previous-value registers track the buses even while capture is disarmed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_int   <= '0;
      r_prev_fp    <= '0;
      r_prev_flags <= '0;
    end else begin
      r_prev_int   <= int_wb_data;
      r_prev_fp    <= fp_wb_data_out;
      r_prev_flags <= fp_flags_out;
    end
  end

  assign w_chg_int  = (int_wb_data != r_prev_int);
  assign w_chg_fp   = (fp_wb_data_out != r_prev_fp) | (fp_flags_out != r_prev_flags);
  assign w_push_req = enable & (w_chg_int | w_chg_fp);
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push_ok;

  always_comb begin
    w_entry          = '0;
    w_entry.chg_int  = w_chg_int;
    w_entry.chg_fp   = w_chg_fp;
    w_entry.flags    = fp_flags_out;
    w_entry.int_data = int_wb_data;
    w_entry.fp_data  = fp_wb_data_out;
  end

  trace_fifo #(
    .WIDTH (TRACE_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push_ok),
    .i_wdata   (w_entry),
    .i_pop     (w_pop),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_cur_byte  = frame_byte(r_frame, r_byte_idx);
  assign w_bit_inc   = r_bit_idx + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state plus next line level, so uart_txd leaves a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_byte_idx;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_nxt  = 1'b1;
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_byte_nxt  = '0;
          w_txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
          w_txd_nxt   = w_cur_byte[0];
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt = w_bit_inc;
            w_txd_nxt = w_cur_byte[w_bit_inc];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_byte_idx < LAST_BYTE) begin
            w_byte_nxt  = r_byte_idx + 4'd1;
            w_state_nxt = START;
            w_txd_nxt   = 1'b0;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_byte_nxt  = '0;
            w_state_nxt = START;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_txd      <= 1'b1;
      r_frame    <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_byte_idx <= w_byte_nxt;
      r_txd      <= w_txd_nxt;
      if (w_pop) r_frame <= w_head;
      r_busy     <= (w_state_nxt != IDLE) | (w_count != '0);
      // A drop in the same cycle beats the clear.
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign uart_txd = r_txd;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_wb_trace_uart_tx.sv
// Bench for wb_trace_uart_tx: directed frame vectors, overflow/enable/reset
// sequences and randomized traffic against a snapshot/frame-timer model.
module tb_wb_trace_uart_tx;

  localparam int CPB       = 4;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = 100 * CPB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] int_wb_data;
  logic [31:0] fp_wb_data_out;
  logic [4:0]  fp_flags_out;
  logic        overflow_clr;
  logic        uart_txd;
  logic        busy;
  logic        overflow;

  always #5 clk = ~clk;

  wb_trace_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .int_wb_data    (int_wb_data),
    .fp_wb_data_out (fp_wb_data_out),
    .fp_flags_out   (fp_flags_out),
    .overflow_clr   (overflow_clr),
    .uart_txd       (uart_txd),
    .busy           (busy),
    .overflow       (overflow)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of snapshots and a frame timer of FRAME_CYC edges.
  typedef struct {
    logic        ci;
    logic        cf;
    logic [4:0]  fl;
    logic [31:0] iv;
    logic [31:0] fv;
  } snap_t;

  snap_t       m_q[$];
  logic [7:0]  m_cur [10];
  int          m_t;
  int          m_free;
  logic        m_ovf;
  logic [31:0] m_prev_int;
  logic [31:0] m_prev_fp;
  logic [4:0]  m_prev_fl;

  function automatic logic [7:0] snap_byte(input snap_t s, input int k);
    if (k == 0) return 8'hA5;
    if (k == 1) return {1'b0, s.fl, s.cf, s.ci};
    if (k < 6)  return 8'(s.iv >> (8 * (k - 2)));
    return 8'(s.fv >> (8 * (k - 6)));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_t        = 0;
    m_free     = 0;
    m_ovf      = 1'b0;
    m_prev_int = '0;
    m_prev_fp  = '0;
    m_prev_fl  = '0;
  endtask

  task automatic model_edge();
    snap_t s;
    bit    pop;
    bit    drop;
    int    pre;
    m_t++;
    s.ci = (int_wb_data != m_prev_int);
    s.cf = (fp_wb_data_out != m_prev_fp) || (fp_flags_out != m_prev_fl);
    s.fl = fp_flags_out;
    s.iv = int_wb_data;
    s.fv = fp_wb_data_out;
    pre  = m_q.size();
    pop  = (pre > 0) && (m_t >= m_free);
    drop = 1'b0;
    if (pop) begin
      snap_t h;
      h = m_q.pop_front();
      for (int k = 0; k < 10; k++) m_cur[k] = snap_byte(h, k);
      m_free = m_t + FRAME_CYC;
    end
    if (enable && (s.ci || s.cf)) begin
      if (pre < DEPTH || pop) m_q.push_back(s);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    m_prev_int = int_wb_data;
    m_prev_fp  = fp_wb_data_out;
    m_prev_fl  = fp_flags_out;
  endtask

  function automatic logic m_line();
    int off, k, pos;
    if (m_t >= m_free) return 1'b1;
    off = m_t - (m_free - FRAME_CYC);
    k   = off / CPB;
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_cur[k / 10][pos - 1];
  endfunction

  // Simple line receiver sampling mid-bit.
  bit         rx_active = 1'b0;
  int         rx_ph = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_q[$];

  task automatic rx_sample();
    if (!reset_n) begin
      rx_active = 1'b0;
      return;
    end
    if (!rx_active) begin
      if (uart_txd == 1'b0) begin
        rx_active = 1'b1;
        rx_ph     = 0;
        rx_byte   = '0;
      end
    end else begin
      rx_ph++;
      if (rx_ph >= 6 && rx_ph <= 34 && (rx_ph % 4) == 2) rx_byte[3'((rx_ph - 6) / 4)] = uart_txd;
      if (rx_ph == 38) begin
        chk("rx_stop_bit", uart_txd, 1);
        rx_q.push_back(rx_byte);
      end
      if (rx_ph == 39) rx_active = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    rx_sample();
    chk("txd", uart_txd, m_line());
    chk("busy", busy, (m_t < m_free));
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || rx_active) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles", k);
    end
  endtask

  typedef struct {
    logic [31:0] iv;
    logic [31:0] fv;
    logic [4:0]  fl;
    logic [7:0]  exp [10];
  } vec_t;

  vec_t vecs[4];

  initial begin
    int k;

    vecs[0].iv = 32'h0000_0005; vecs[0].fv = 32'h0000_0000; vecs[0].fl = 5'h00;
    vecs[0].exp = '{8'hA5, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].iv = 32'h0000_0005; vecs[1].fv = 32'h3F80_0000; vecs[1].fl = 5'h01;
    vecs[1].exp = '{8'hA5, 8'h06, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h3F};
    vecs[2].iv = 32'h1234_5678; vecs[2].fv = 32'hDEAD_BEEF; vecs[2].fl = 5'h1F;
    vecs[2].exp = '{8'hA5, 8'h7F, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    vecs[3].iv = 32'h1234_5678; vecs[3].fv = 32'hDEAD_BEEF; vecs[3].fl = 5'h00;
    vecs[3].exp = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    reset_n        = 1'b1;
    enable         = 1'b1;
    int_wb_data    = '0;
    fp_wb_data_out = '0;
    fp_flags_out   = '0;
    overflow_clr   = 1'b0;
    model_reset();
    #2;

    // Reset: held 3 cycles, then a quiet line with static inputs
    reset_n = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    repeat (200) tick();
    chk("rst_quiet_bytes", rx_q.size(), 0);

    // Directed frames: content, start latency and frame length
    for (int i = 0; i < 4; i++) begin
      rx_q.delete();
      int_wb_data    = vecs[i].iv;
      fp_wb_data_out = vecs[i].fv;
      fp_flags_out   = vecs[i].fl;
      tick();
      chk($sformatf("v%0d_push_txd", i), uart_txd, 1);
      chk($sformatf("v%0d_push_busy", i), busy, 0);
      tick();
      chk($sformatf("v%0d_start_txd", i), uart_txd, 0);
      chk($sformatf("v%0d_start_busy", i), busy, 1);
      k = 0;
      while (busy && k < 2 * FRAME_CYC) begin
        tick();
        k++;
      end
      chk($sformatf("v%0d_frame_len", i), k, FRAME_CYC);
      chk($sformatf("v%0d_nbytes", i), rx_q.size(), 10);
      for (int b = 0; b < 10; b++) begin
        if (b < rx_q.size()) chk($sformatf("v%0d_byte%0d", i, b), rx_q[b], vecs[i].exp[b]);
      end
      wait_idle(2 * FRAME_CYC);
    end

    // Overflow: ten back-to-back changes, ninth queued, tenth dropped
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      int_wb_data = 32'h100 + i;
      tick();
      chk($sformatf("ovf_step%0d", i), overflow, (i == 9));
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    wait_idle(10 * FRAME_CYC);
    chk("ovf_nbytes", rx_q.size(), 90);
    for (int j = 0; j < 9; j++) begin
      if (10 * j + 3 < rx_q.size()) begin
        chk($sformatf("ovf_f%0d_sync", j), rx_q[10 * j], 8'hA5);
        chk($sformatf("ovf_f%0d_int0", j), rx_q[10 * j + 2], 8'(j));
        chk($sformatf("ovf_f%0d_int1", j), rx_q[10 * j + 3], 8'h01);
      end
    end

    // Enable gating: changes while disarmed are not replayed on arming
    rx_q.delete();
    enable         = 1'b0;
    int_wb_data    = $urandom;
    fp_wb_data_out = $urandom;
    fp_flags_out   = 5'($urandom);
    repeat (3) tick();
    enable = 1'b1;
    repeat (200) tick();
    chk("gate_nbytes", rx_q.size(), 0);
    chk("gate_busy", busy, 0);

    // Randomized traffic with overflow and clears
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)      int_wb_data    = $urandom;
      else if (r < 5) fp_wb_data_out = $urandom;
      else if (r < 6) fp_flags_out   = 5'($urandom);
      enable       = ($urandom_range(0, 9) != 0);
      overflow_clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    overflow_clr = 1'b0;
    enable       = 1'b1;
    wait_idle(10 * FRAME_CYC);

    // Reset during byte 4 with three snapshots queued
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int_wb_data = 32'hA0 + i;
      tick();
    end
    repeat (160) tick();
    reset_n = 1'b0;
    model_reset();
    int_wb_data    = '0;
    fp_wb_data_out = '0;
    fp_flags_out   = '0;
    #1;
    chk("mid_rst_txd_async", uart_txd, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    rx_q.delete();
    repeat (800) tick();
    chk("mid_rst_nbytes", rx_q.size(), 0);
    chk("mid_rst_busy_after", busy, 0);
    chk("mid_rst_txd_after", uart_txd, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
